// File: rtl/chip8_mem_arbiter.sv
// rtl/chip8_mem_arbiter.sv - three-port arbiter for the shared CHIP-8 system RAM
//
// Shares one single-port synchronous RAM (1-cycle read latency) between
// video scanout (port 0), the PPU sprite engine (port 1) and the CPU (port 2).
// At most one access is granted per cycle. Read data returns on the shared
// rdata bus with a per-port rvalid strobe. A lock lets the PPU or the CPU
// make a read-modify-write sequence atomic against the other.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to make PPU and CPU alternate.
// Without it, the PPU always wins over the CPU.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req0, addr0             video read request (read-only port)
//   reqN, weN, addrN,       PPU (N=1) / CPU (N=2) request, write enable,
//   wdataN, lockN           address, write data, lock request
//   gnt0..gnt2              combinational grants, at most one high
//   rvalid0..rvalid2        registered read-return strobes
//   rdata                   shared read-return bus (RAM output)
//   ram_addr, ram_we,       RAM command for the granted port
//   ram_wdata, ram_rdata    (all zero when idle) and the RAM read data

module chip8_mem_arbiter #(
   parameter int AW = 12,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   input  logic          lock1,
   input  logic          req2,
   input  logic          we2,
   input  logic [AW-1:0] addr2,
   input  logic [DW-1:0] wdata2,
   input  logic          lock2,
   output logic          gnt0,
   output logic          gnt1,
   output logic          gnt2,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic          rvalid2,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   // Lock register: the state value doubles as the owner port number.
   typedef enum logic [1:0] {
      LOCK_NONE = 2'd0,
      LOCK_PPU  = 2'd1,
      LOCK_CPU  = 2'd2
   } lock_state_t;

   lock_state_t lock_state;
   lock_state_t lock_next;

   logic ppu_ok;
   logic cpu_ok;

`ifdef ARB_ROUND_ROBIN_EN
   // 0 = PPU preferred, 1 = CPU preferred.
   logic rr_ptr_cpu;

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_cpu <= 1'b0;
      end else if (gnt1) begin
         rr_ptr_cpu <= 1'b1;
      end else if (gnt2) begin
         rr_ptr_cpu <= 1'b0;
      end
   end
`endif

   // A held lock blocks only the other lockable port; video is read-only
   // and may interleave without disturbing the owner's sequence.
   assign ppu_ok = req1 && (lock_state != LOCK_CPU);
   assign cpu_ok = req2 && (lock_state != LOCK_PPU);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      gnt2 = 1'b0;
      if (!reset) begin
         if (req0) begin
            gnt0 = 1'b1;
         end else if (ppu_ok && cpu_ok) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (rr_ptr_cpu) begin
               gnt2 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
`else
            gnt1 = 1'b1;
`endif
         end else if (ppu_ok) begin
            gnt1 = 1'b1;
         end else if (cpu_ok) begin
            gnt2 = 1'b1;
         end
      end
   end

   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (gnt0) begin
         ram_addr = addr0;
      end else if (gnt1) begin
         ram_addr  = addr1;
         ram_we    = we1;
         ram_wdata = wdata1;
      end else if (gnt2) begin
         ram_addr  = addr2;
         ram_we    = we2;
         ram_wdata = wdata2;
      end
   end

   // A grant to a lockable port is only possible when the lock is free or
   // already owned by that port, so the grant's lock bit alone decides.
   always_comb begin
      lock_next = lock_state;
      if (gnt1) begin
         lock_next = lock1 ? LOCK_PPU : LOCK_NONE;
      end else if (gnt2) begin
         lock_next = lock2 ? LOCK_CPU : LOCK_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_state <= LOCK_NONE;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         rvalid2    <= 1'b0;
      end else begin
         lock_state <= lock_next;
         rvalid0    <= gnt0;
         rvalid1    <= gnt1 && !we1;
         rvalid2    <= gnt2 && !we2;
      end
   end

   assign rdata = ram_rdata;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb/tb_chip8_mem_arbiter.sv - self-checking bench for chip8_mem_arbiter

module tb_chip8_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, req2;
   logic        we1, we2, lock1, lock2;
   logic [11:0] addr0, addr1, addr2;
   logic [7:0]  wdata1, wdata2;
   logic        gnt0, gnt1, gnt2;
   logic        rvalid0, rvalid1, rvalid2;
   logic [7:0]  rdata;
   logic [11:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        mem_load;

   always #5 clk = ~clk;

   chip8_mem_arbiter #(.AW(12), .DW(8)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
      .req2(req2), .we2(we2), .addr2(addr2), .wdata2(wdata2), .lock2(lock2),
      .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2),
      .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   function automatic logic [7:0] init_val(int i);
      logic [7:0] lo;
      lo = 8'(i);
      return (i == 12'h200) ? 8'hA2 : (lo ^ 8'h5A);
   endfunction

   // RAM macro model driven by the DUT's ram_* outputs.
   logic [7:0] mem [4096];
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
      end else begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   // Reference model state.
   logic [7:0] ref_mem [4096];
   int         m_locked, m_owner, m_pref;
   logic [2:0] exp_rv;
   logic [7:0] exp_rd;
   int         checks = 0;
   int         failures = 0;
   logic [2:0] last_gnt;
   logic [11:0] last_addr;
   logic       last_we;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Which port the rules say should win this cycle (-1 = none).
   function automatic int predict();
      bit c1, c2;
      if (reset) return -1;
      if (req0) return 0;
      c1 = req1 && (m_locked == 0 || m_owner == 1);
      c2 = req2 && (m_locked == 0 || m_owner == 2);
      if (c1 && c2) begin
`ifdef ARB_ROUND_ROBIN_EN
         return m_pref;
`else
         return 1;
`endif
      end
      if (c1) return 1;
      if (c2) return 2;
      return -1;
   endfunction

   task automatic tick();
      int w;
      logic [2:0] eg;
      logic [11:0] ea;
      logic ewe, lk;
      logic [7:0] ed;
      @(negedge clk);
      w = predict();
      eg = 3'b000; ea = 12'h0; ewe = 1'b0; ed = 8'h0; lk = 1'b0;
      case (w)
         0: begin eg = 3'b001; ea = addr0; end
         1: begin eg = 3'b010; ea = addr1; ewe = we1; ed = wdata1; lk = lock1; end
         2: begin eg = 3'b100; ea = addr2; ewe = we2; ed = wdata2; lk = lock2; end
         default: ;
      endcase
      chk("gnt", {29'd0, gnt2, gnt1, gnt0}, {29'd0, eg});
      chk("ram_addr", {20'd0, ram_addr}, {20'd0, ea});
      chk("ram_we", {31'd0, ram_we}, {31'd0, ewe});
      chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, ed});
      last_gnt = {gnt2, gnt1, gnt0};
      last_addr = ram_addr;
      last_we = ram_we;
      @(posedge clk);
      #1;
      exp_rv = 3'b000;
      if (reset) begin
         m_locked = 0; m_owner = 0; m_pref = 1;
      end else if (w >= 0) begin
         if (!ewe) begin
            exp_rv = eg;
            exp_rd = ref_mem[ea];
         end else begin
            ref_mem[ea] = ed;
         end
         if (w > 0) begin
            if (lk) begin
               m_locked = 1; m_owner = w;
            end else if (m_locked != 0 && m_owner == w) begin
               m_locked = 0; m_owner = 0;
            end
            m_pref = (w == 1) ? 2 : 1;
         end
      end
      chk("rvalid", {29'd0, rvalid2, rvalid1, rvalid0}, {29'd0, exp_rv});
      if (exp_rv != 3'b000) chk("rdata", {24'd0, rdata}, {24'd0, exp_rd});
   endtask

   task automatic drive(logic r0, logic [11:0] a0,
                        logic r1, logic w1, logic l1, logic [11:0] a1, logic [7:0] d1,
                        logic r2, logic w2, logic l2, logic [11:0] a2, logic [7:0] d2);
      req0 = r0; addr0 = a0;
      req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
      req2 = r2; we2 = w2; lock2 = l2; addr2 = a2; wdata2 = d2;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   typedef struct {
      logic        r0;
      logic [11:0] a0;
      logic        r1, w1, l1;
      logic [11:0] a1;
      logic [7:0]  d1;
      logic        r2, w2, l2;
      logic [11:0] a2;
      logic [7:0]  d2;
      logic [2:0]  egnt;
      logic [11:0] eaddr;
      logic        ewe;
      logic [2:0]  erv;
      logic [7:0]  erd;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [2:0] eg;
      // r0 a0 | r1 w1 l1 a1 d1 | r2 w2 l2 a2 d2 | egnt eaddr ewe | erv erd
      tbl[0] = '{0, 12'h000, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 3'b000, 12'h000, 0, 3'b000, 8'h00};
      tbl[1] = '{0, 12'h000, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0, 12'h200, 8'h00, 3'b100, 12'h200, 0, 3'b100, 8'hA2};
      tbl[2] = '{1, 12'h010, 1, 0, 0, 12'h020, 8'h00, 1, 0, 0, 12'h030, 8'h00, 3'b001, 12'h010, 0, 3'b001, 8'h4A};
      tbl[3] = '{1, 12'h011, 1, 0, 0, 12'h020, 8'h00, 1, 0, 0, 12'h030, 8'h00, 3'b001, 12'h011, 0, 3'b001, 8'h4B};
      tbl[4] = '{1, 12'h012, 1, 0, 0, 12'h020, 8'h00, 1, 0, 0, 12'h030, 8'h00, 3'b001, 12'h012, 0, 3'b001, 8'h48};
      tbl[5] = '{0, 12'h000, 1, 1, 0, 12'h040, 8'h77, 0, 0, 0, 12'h000, 8'h00, 3'b010, 12'h040, 1, 3'b000, 8'h00};
      tbl[6] = '{0, 12'h000, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0, 12'h040, 8'h00, 3'b100, 12'h040, 0, 3'b100, 8'h77};
      tbl[7] = '{0, 12'h000, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 3'b000, 12'h000, 0, 3'b000, 8'h00};

      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
      m_locked = 0; m_owner = 0; m_pref = 1;
      exp_rv = 3'b000; exp_rd = 8'h00;
      reset = 1'b1; mem_load = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0; mem_load = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].r0, tbl[i].a0,
               tbl[i].r1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1,
               tbl[i].r2, tbl[i].w2, tbl[i].l2, tbl[i].a2, tbl[i].d2);
         tick();
         chk($sformatf("tbl%0d_gnt", i), {29'd0, last_gnt}, {29'd0, tbl[i].egnt});
         chk($sformatf("tbl%0d_addr", i), {20'd0, last_addr}, {20'd0, tbl[i].eaddr});
         chk($sformatf("tbl%0d_we", i), {31'd0, last_we}, {31'd0, tbl[i].ewe});
         chk($sformatf("tbl%0d_rvalid", i), {29'd0, rvalid2, rvalid1, rvalid0}, {29'd0, tbl[i].erv});
         if (tbl[i].erv != 3'b000)
            chk($sformatf("tbl%0d_rdata", i), {24'd0, rdata}, {24'd0, tbl[i].erd});
      end

      // PPU and CPU writing continuously.
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 1, 1, 0, 12'h300, 8'h11, 1, 1, 0, 12'h301, 8'h22);
         tick();
`ifdef ARB_ROUND_ROBIN_EN
         eg = (k % 2 == 0) ? 3'b010 : 3'b100;
`else
         eg = 3'b010;
`endif
         chk($sformatf("contend%0d_gnt", k), {29'd0, last_gnt}, {29'd0, eg});
      end
      idle();
      tick();

      // PPU locked read-modify-write of 0x108 against a waiting CPU.
      drive(0, 0, 1, 0, 1, 12'h108, 8'h00, 0, 0, 0, 12'h000, 8'h00);
      tick();
      chk("lock_rd_gnt", {29'd0, last_gnt}, 32'd2);
      chk("lock_rd_data", {24'd0, rdata}, 32'h52);
      drive(0, 0, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0, 12'h220, 8'h00);
      tick();
      chk("lock_block0", {29'd0, last_gnt}, 32'd0);
      tick();
      chk("lock_block1", {29'd0, last_gnt}, 32'd0);
      drive(0, 0, 1, 1, 0, 12'h108, 8'hC3, 1, 0, 0, 12'h220, 8'h00);
      tick();
      chk("lock_wr_gnt", {29'd0, last_gnt}, 32'd2);
      drive(0, 0, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0, 12'h220, 8'h00);
      tick();
      chk("unlock_cpu_gnt", {29'd0, last_gnt}, 32'd4);
      idle();
      tick();

      // Video interleaving during a PPU lock, then reset releasing the lock.
      drive(0, 0, 1, 0, 1, 12'h110, 8'h00, 0, 0, 0, 12'h000, 8'h00);
      tick();
      chk("vlock_gnt", {29'd0, last_gnt}, 32'd2);
      drive(1, 12'h020, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0, 12'h220, 8'h00);
      tick();
      chk("video_in_lock", {29'd0, last_gnt}, 32'd1);
      drive(0, 0, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0, 12'h220, 8'h00);
      tick();
      chk("lock_kept", {29'd0, last_gnt}, 32'd0);
      drive(0, 0, 1, 0, 1, 12'h111, 8'h00, 1, 0, 0, 12'h220, 8'h00);
      tick();
      chk("relock_gnt", {29'd0, last_gnt}, 32'd2);
      drive(0, 0, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0, 12'h220, 8'h00);
      reset = 1'b1;
      tick();
      chk("reset_gnt", {29'd0, last_gnt}, 32'd0);
      chk("reset_rvalid", {29'd0, rvalid2, rvalid1, rvalid0}, 32'd0);
      reset = 1'b0;
      tick();
      chk("post_reset_gnt", {29'd0, last_gnt}, 32'd4);
      idle();
      tick();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 3) == 0, 12'($urandom),
               1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 12'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 12'($urandom), 8'($urandom));
         reset = ($urandom_range(0, 59) == 0);
         tick();
      end
      reset = 1'b0;
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
